extra_slot_arbiter: RTL and testbench

EXTRA_SLOT_ARBITER -- requirements
Module: extra_slot_arbiter

---
 rtl/extra_slot_arbiter.sv | 162 ++++++++++++++++
 tb/tb_extra_slot_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/extra_slot_arbiter.sv
// Extra bus cycle arbiter: grants each extra slot to one of four requesters
// (floppy int, floppy ext, SCSI DMA, audio) using round-robin order, with a
// starvation override that forces audio after it has lost too many slots.
module extra_slot_arbiter #(
  parameter int ADDR_W         = 22,
  parameter int AUDIO_MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  slot_begin,
  input  logic                  slot_end,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   req_addr,
  output logic [3:0]            grant,
  output logic [3:0]            done,
  output logic [ADDR_W-1:0]     slot_addr,
  output logic                  slot_active,
  output logic                  proto_err
);

  // The wait counter must be able to hold AUDIO_MAX_WAIT itself.
  localparam int CW = (AUDIO_MAX_WAIT < 1) ? 1 : $clog2(AUDIO_MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(AUDIO_MAX_WAIT);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t             state_r;
  logic [1:0]         rr_ptr_r;
  logic [CW-1:0]      audio_wait_r;

  logic [1:0]         rr_win_s;
  logic               rr_found_s;
  logic               audio_force_s;
  logic [1:0]         winner_s;
  logic               any_req_s;
  logic [CW-1:0]      audio_wait_next_s;
  logic [ADDR_W-1:0]  winner_addr_s;

  // Binary index to one-hot grant vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] vec;
    case (idx)
      2'd0:    vec = 4'b0001;
      2'd1:    vec = 4'b0010;
      2'd2:    vec = 4'b0100;
      2'd3:    vec = 4'b1000;
      default: vec = 4'b0000;
    endcase
    return vec;
  endfunction

  // Round-robin search upward from rr_ptr, wrapping modulo 4.
  always_comb begin
    rr_win_s   = rr_ptr_r;
    rr_found_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!rr_found_s && req[rr_ptr_r + 2'(i)]) begin
        rr_win_s   = rr_ptr_r + 2'(i);
        rr_found_s = 1'b1;
      end else begin
        rr_win_s   = rr_win_s;
        rr_found_s = rr_found_s;
      end
    end
  end

  // Winner selection (audio override beats round-robin) and audio wait update.
  always_comb begin
    any_req_s     = |req;
    audio_force_s = req[3] && (audio_wait_r == WAIT_MAX);
    if (audio_force_s) begin
      winner_s = 2'd3;
    end else begin
      winner_s = rr_win_s;
    end
    if (!req[3]) begin
      audio_wait_next_s = {CW{1'b0}};
    end else if (winner_s == 2'd3) begin
      audio_wait_next_s = {CW{1'b0}};
    end else if (audio_wait_r == WAIT_MAX) begin
      audio_wait_next_s = audio_wait_r;
    end else begin
      audio_wait_next_s = audio_wait_r + CW'(1);
    end
  end

  // Address of the selected winner.
  always_comb begin
    case (winner_s)
      2'd0:    winner_addr_s = req_addr[0*ADDR_W +: ADDR_W];
      2'd1:    winner_addr_s = req_addr[1*ADDR_W +: ADDR_W];
      2'd2:    winner_addr_s = req_addr[2*ADDR_W +: ADDR_W];
      2'd3:    winner_addr_s = req_addr[3*ADDR_W +: ADDR_W];
      default: winner_addr_s = {ADDR_W{1'b0}};
    endcase
  end

  // Slot state machine: a slot_begin always closes any open slot (done to the
  // old owner) and then arbitrates, so back-to-back slots never lose a clk.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_r      <= IDLE;
      grant        <= 4'b0000;
      done         <= 4'b0000;
      slot_addr    <= {ADDR_W{1'b0}};
      slot_active  <= 1'b0;
      proto_err    <= 1'b0;
      rr_ptr_r     <= 2'd0;
      audio_wait_r <= {CW{1'b0}};
    end else begin
      if (slot_begin) begin
        if (state_r == GRANTED) begin
          done <= grant;
          if (!slot_end) begin
            proto_err <= 1'b1;
          end else begin
            proto_err <= proto_err;
          end
        end else begin
          done      <= 4'b0000;
          proto_err <= proto_err;
        end
        audio_wait_r <= audio_wait_next_s;
        if (any_req_s) begin
          state_r     <= GRANTED;
          grant       <= onehot4(winner_s);
          slot_addr   <= winner_addr_s;
          slot_active <= 1'b1;
          rr_ptr_r    <= winner_s + 2'd1;
        end else begin
          state_r     <= IDLE;
          grant       <= 4'b0000;
          slot_addr   <= {ADDR_W{1'b0}};
          slot_active <= 1'b0;
          rr_ptr_r    <= rr_ptr_r;
        end
      end else if (slot_end && (state_r == GRANTED)) begin
        state_r      <= IDLE;
        done         <= grant;
        grant        <= 4'b0000;
        slot_addr    <= {ADDR_W{1'b0}};
        slot_active  <= 1'b0;
        proto_err    <= proto_err;
        rr_ptr_r     <= rr_ptr_r;
        audio_wait_r <= audio_wait_r;
      end else begin
        state_r      <= state_r;
        done         <= 4'b0000;
        grant        <= grant;
        slot_addr    <= slot_addr;
        slot_active  <= slot_active;
        proto_err    <= proto_err;
        rr_ptr_r     <= rr_ptr_r;
        audio_wait_r <= audio_wait_r;
      end
    end
  end

endmodule

// File: tb/tb_extra_slot_arbiter.sv
// Directed bench for extra_slot_arbiter. Instance A uses the default audio
// wait limit (3); instance B uses a limit of 1 so the override is visible.
module tb_extra_slot_arbiter;

  localparam int AW = 22;

  logic            clk;
  logic            resetN;
  logic            slotBegin;
  logic            slotEnd;
  logic [3:0]      req;
  logic [4*AW-1:0] reqAddr;

  logic [3:0]      grantA, doneA, grantB, doneB;
  logic [AW-1:0]   addrA, addrB;
  logic            activeA, activeB, errA, errB;

  localparam logic [AW-1:0] A0 = 22'h0A0A01;
  localparam logic [AW-1:0] A1 = 22'h1B1B12;
  localparam logic [AW-1:0] A2 = 22'h2C2C23;
  localparam logic [AW-1:0] A3 = 22'h3D3D34;

  int checks = 0;
  int errors = 0;

  extra_slot_arbiter #(.ADDR_W(AW), .AUDIO_MAX_WAIT(3)) dutA (
    .clk(clk), ._reset(resetN), .slot_begin(slotBegin), .slot_end(slotEnd),
    .req(req), .req_addr(reqAddr), .grant(grantA), .done(doneA),
    .slot_addr(addrA), .slot_active(activeA), .proto_err(errA)
  );

  extra_slot_arbiter #(.ADDR_W(AW), .AUDIO_MAX_WAIT(1)) dutB (
    .clk(clk), ._reset(resetN), .slot_begin(slotBegin), .slot_end(slotEnd),
    .req(req), .req_addr(reqAddr), .grant(grantB), .done(doneB),
    .slot_addr(addrB), .slot_active(activeB), .proto_err(errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idleA(input string tag);
    chk({tag, "_grant"},  64'(grantA),  64'h0);
    chk({tag, "_addr"},   64'(addrA),   64'h0);
    chk({tag, "_active"}, 64'(activeA), 64'h0);
  endtask

  logic [3:0] expA [4];
  logic [3:0] expB [4];
  logic [AW-1:0] expAddrA [4];

  initial begin
    resetN    = 1'b0;
    slotBegin = 1'b0;
    slotEnd   = 1'b0;
    req       = 4'b0000;
    reqAddr   = {A3, A2, A1, A0};
    expA = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    expB = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
    expAddrA = '{A0, A1, A2, A3};

    // Reset state
    tick(); tick();
    idleA("rst");
    chk("rst_done", 64'(doneA), 64'h0);
    chk("rst_err",  64'(errA),  64'h0);
    resetN = 1'b1;

    // Basic grant, hold while req dropped, done pulse, next requester eligible
    req = 4'b0011; slotBegin = 1'b1; tick(); slotBegin = 1'b0;
    chk("g1_grant",  64'(grantA),  64'h1);
    chk("g1_addr",   64'(addrA),   64'(A0));
    chk("g1_active", 64'(activeA), 64'h1);
    chk("g1_done",   64'(doneA),   64'h0);
    req = 4'b0000; tick();
    chk("hold_grant", 64'(grantA), 64'h1);
    chk("hold_addr",  64'(addrA),  64'(A0));
    req = 4'b0011; slotEnd = 1'b1; tick(); slotEnd = 1'b0;
    chk("e1_done", 64'(doneA), 64'h1);
    idleA("e1");
    tick();
    chk("e1_done_once", 64'(doneA), 64'h0);
    slotBegin = 1'b1; tick(); slotBegin = 1'b0;
    chk("g2_grant", 64'(grantA), 64'h2);
    chk("g2_addr",  64'(addrA),  64'(A1));
    slotEnd = 1'b1; tick(); slotEnd = 1'b0;
    chk("e2_done", 64'(doneA), 64'h2);

    // slot_end in IDLE is ignored
    tick();
    slotEnd = 1'b1; tick(); slotEnd = 1'b0;
    chk("idle_end_done", 64'(doneA), 64'h0);
    chk("idle_end_err",  64'(errA),  64'h0);

    // Wasted slot with no requests
    req = 4'b0000; slotBegin = 1'b1; tick(); slotBegin = 1'b0;
    idleA("waste");

    // Round-robin over four slots; audio loses 3 times in A, forced in B
    resetN = 1'b0; tick(); resetN = 1'b1;
    req = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      slotBegin = 1'b1; tick(); slotBegin = 1'b0;
      chk($sformatf("rr%0d_grantA", s), 64'(grantA), 64'(expA[s]));
      chk($sformatf("rr%0d_addrA", s),  64'(addrA),  64'(expAddrA[s]));
      chk($sformatf("rr%0d_grantB", s), 64'(grantB), 64'(expB[s]));
      slotEnd = 1'b1; tick(); slotEnd = 1'b0;
      chk($sformatf("rr%0d_doneA", s), 64'(doneA), 64'(expA[s]));
      chk($sformatf("rr%0d_doneB", s), 64'(doneB), 64'(expB[s]));
    end

    // B: audio loses once, then req[3]=0 clears its counter, so no override
    slotBegin = 1'b1; tick(); slotBegin = 1'b0;
    chk("clr1_grantB", 64'(grantB), 64'h1);
    slotEnd = 1'b1; tick(); slotEnd = 1'b0;
    req = 4'b0001; slotBegin = 1'b1; tick(); slotBegin = 1'b0;
    chk("clr2_grantB", 64'(grantB), 64'h1);
    slotEnd = 1'b1; tick(); slotEnd = 1'b0;
    req = 4'b1111; slotBegin = 1'b1; tick(); slotBegin = 1'b0;
    chk("clr3_grantB", 64'(grantB), 64'h2);
    chk("clr3_grantA", 64'(grantA), 64'h2);
    slotEnd = 1'b1; tick(); slotEnd = 1'b0;

    // Simultaneous end and begin: done and new grant on the same edge
    resetN = 1'b0; tick(); resetN = 1'b1;
    req = 4'b0011; slotBegin = 1'b1; tick();
    chk("bb_grant0", 64'(grantA), 64'h1);
    slotEnd = 1'b1; tick(); slotBegin = 1'b0; slotEnd = 1'b0;
    chk("bb_done",   64'(doneA),   64'h1);
    chk("bb_grant",  64'(grantA),  64'h2);
    chk("bb_active", 64'(activeA), 64'h1);
    chk("bb_err",    64'(errA),    64'h0);
    tick();
    chk("bb_done_once", 64'(doneA),  64'h0);
    chk("bb_hold",      64'(grantA), 64'h2);

    // slot_begin while GRANTED: protocol error, old slot done, rearbitrate
    slotBegin = 1'b1; tick(); slotBegin = 1'b0;
    chk("pe_err",   64'(errA),   64'h1);
    chk("pe_done",  64'(doneA),  64'h2);
    chk("pe_grant", 64'(grantA), 64'h1);
    chk("pe_addr",  64'(addrA),  64'(A0));
    tick();
    chk("pe_sticky", 64'(errA),  64'h1);
    chk("pe_done0",  64'(doneA), 64'h0);

    // Reset mid-slot, with reset beating a coincident slot_end
    resetN = 1'b0; slotEnd = 1'b1; tick(); slotEnd = 1'b0;
    idleA("mid_rst");
    chk("mid_rst_done", 64'(doneA), 64'h0);
    chk("mid_rst_err",  64'(errA),  64'h0);
    resetN = 1'b1; tick();
    chk("post_rst_done",  64'(doneA),  64'h0);
    chk("post_rst_grant", 64'(grantA), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
